// File: rtl/soi_trace_buffer_pkg.sv
// Shared types and helpers for the SOI trace buffer.
// Default widths mirror the top-level parameter defaults.
package soi_trace_pkg;

  localparam int DEF_SOI_W = 1;
  localparam int DEF_TS_W  = 16;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_CNT_W = 8;
  localparam int PTR_W     = $clog2(DEF_DEPTH);

  typedef struct packed {
    logic                 lost;
    logic [DEF_TS_W-1:0]  ts;
    logic [DEF_SOI_W-1:0] val;
  } soi_rec_t;

  // Baseline on enable rise, otherwise on value change.
  function automatic logic trig(
    input logic en,
    input logic en_d,
    input logic chg
  );
    return en && (!en_d || chg);
  endfunction

endpackage

// File: rtl/soi_trace_buffer_if.sv
// Host-side read port of the SOI trace buffer.
// Valid/ready handshake with first-word-fall-through data.
interface soi_trace_buffer_if #(
  parameter int SOI_W = 1,
  parameter int TS_W  = 16
);

  logic             rd_valid;
  logic             rd_ready;
  logic [SOI_W-1:0] rd_value;
  logic [TS_W-1:0]  rd_ts;
  logic             rd_lost;

  modport master (
    output rd_valid,
    output rd_value,
    output rd_ts,
    output rd_lost,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_value,
    input  rd_ts,
    input  rd_lost,
    output rd_ready
  );

endinterface

// File: rtl/soi_trace_buffer_fifo.sv
// Generic circular FWFT FIFO; extra pointer MSB separates full from empty.
// Read data is forced to zero while empty.
module soi_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                 (wr_ptr[AW] != rd_ptr[AW]);
  assign count = wr_ptr - rd_ptr;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear)
      mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/soi_trace_buffer.sv
// Samples an SOI signal, records changes with timestamps into a FIFO,
// and counts events dropped while the FIFO is full.
module soi_trace_buffer
  import soi_trace_pkg::*;
#(
  parameter int SOI_W = 1,
  parameter int TS_W  = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clear,
  input  logic [SOI_W-1:0]        soi_in,
  soi_trace_buffer_if.master      rd,
  output logic [$clog2(DEPTH):0]  count,
  output logic [CNT_W-1:0]        drop_cnt
);

  localparam int RW = 1 + TS_W + SOI_W;

  typedef struct packed {
    logic             lost;
    logic [TS_W-1:0]  ts;
    logic [SOI_W-1:0] val;
  } rec_t;

  logic [TS_W-1:0]  ts_cnt;
  logic [SOI_W-1:0] prev_soi;
  logic             en_d;
  logic             lost_flag;
  logic             evt;
  logic             pop;
  logic             push;
  logic             drop;
  logic             full;
  logic             empty;
  rec_t             wrec;
  rec_t             rrec;

  assign evt  = trig(en, en_d, soi_in != prev_soi);
  assign pop  = !empty && rd.rd_ready;
  assign push = evt && !clear && (!full || pop);
  assign drop = evt && !clear && full && !pop;

  assign wrec = '{lost: lost_flag, ts: ts_cnt, val: soi_in};

  soi_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata (wrec),
    .rdata (rrec),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign rd.rd_valid = !empty;
  assign rd.rd_value = rrec.val;
  assign rd.rd_ts    = rrec.ts;
  assign rd.rd_lost  = rrec.lost;

  // Change tracking runs through clear so no false edge follows it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_soi <= '0;
      en_d     <= 1'b0;
    end else begin
      prev_soi <= soi_in;
      en_d     <= en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt    <= '0;
      lost_flag <= 1'b0;
      drop_cnt  <= '0;
    end else if (clear) begin
      ts_cnt    <= '0;
      lost_flag <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (en) ts_cnt <= ts_cnt + 1'b1;
      if (drop) begin
        lost_flag <= 1'b1;
        if (drop_cnt != {CNT_W{1'b1}})
          drop_cnt <= drop_cnt + 1'b1;
      end else if (push) begin
        lost_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_soi_trace_buffer.sv
// Directed bench: vector table for capture/overflow/drain,
// hand sequences for clear, async reset and timestamp wrap.
module tb_soi_trace_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, clear, soi;
  logic       en1, clear1, soi1;
  logic [3:0] count0, count1;
  logic [7:0] drop0, drop1;

  soi_trace_buffer_if #(.SOI_W(1), .TS_W(16)) rd0 ();
  soi_trace_buffer_if #(.SOI_W(1), .TS_W(4))  rd1 ();

  soi_trace_buffer #(
    .SOI_W(1), .TS_W(16), .DEPTH(8), .CNT_W(8)
  ) u0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clear    (clear),
    .soi_in   (soi),
    .rd       (rd0.master),
    .count    (count0),
    .drop_cnt (drop0)
  );

  soi_trace_buffer #(
    .SOI_W(1), .TS_W(4), .DEPTH(8), .CNT_W(8)
  ) u1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en1),
    .clear    (clear1),
    .soi_in   (soi1),
    .rd       (rd1.master),
    .count    (count1),
    .drop_cnt (drop1)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit en;
    bit soi;
    bit rdy;
    bit v;
    bit val;
    int ts;
    bit lost;
    int cnt;
    int drp;
  } vec_t;

  vec_t tbl [25];
  int   checks = 0;
  int   errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic set_row(input int i, input bit e, input bit s,
                         input bit r, input bit v, input bit val,
                         input int ts, input bit lost, input int cnt,
                         input int drp);
    tbl[i] = '{e, s, r, v, val, ts, lost, cnt, drp};
  endtask

  task automatic chk0(input string tag, input bit v, input bit val,
                      input int ts, input bit lost, input int cnt,
                      input int drp);
    chk({tag, " valid"}, 32'(rd0.rd_valid), 32'(v));
    chk({tag, " value"}, 32'(rd0.rd_value), 32'(val));
    chk({tag, " ts"},    32'(rd0.rd_ts),    32'(ts));
    chk({tag, " lost"},  32'(rd0.rd_lost),  32'(lost));
    chk({tag, " count"}, 32'(count0),       32'(cnt));
    chk({tag, " drop"},  32'(drop0),        32'(drp));
  endtask

  initial begin
    //       i   en soi rdy  v val ts lost cnt drp
    set_row( 0, 0, 1, 0,   0, 0,  0, 0, 0, 0);
    set_row( 1, 0, 1, 0,   0, 0,  0, 0, 0, 0);
    set_row( 2, 1, 1, 0,   1, 1,  0, 0, 1, 0);
    set_row( 3, 1, 0, 0,   1, 1,  0, 0, 2, 0);
    set_row( 4, 1, 1, 0,   1, 1,  0, 0, 3, 0);
    set_row( 5, 1, 0, 0,   1, 1,  0, 0, 4, 0);
    set_row( 6, 1, 1, 0,   1, 1,  0, 0, 5, 0);
    set_row( 7, 1, 0, 0,   1, 1,  0, 0, 6, 0);
    set_row( 8, 1, 1, 0,   1, 1,  0, 0, 7, 0);
    set_row( 9, 1, 0, 0,   1, 1,  0, 0, 8, 0);
    set_row(10, 1, 1, 0,   1, 1,  0, 0, 8, 1);
    set_row(11, 1, 0, 0,   1, 1,  0, 0, 8, 2);
    set_row(12, 1, 1, 0,   1, 1,  0, 0, 8, 3);
    set_row(13, 1, 1, 1,   1, 0,  1, 0, 7, 3);
    set_row(14, 1, 0, 0,   1, 0,  1, 0, 8, 3);
    set_row(15, 1, 1, 1,   1, 1,  2, 0, 8, 3);
    set_row(16, 0, 1, 1,   1, 0,  3, 0, 7, 3);
    set_row(17, 0, 1, 1,   1, 1,  4, 0, 6, 3);
    set_row(18, 0, 1, 1,   1, 0,  5, 0, 5, 3);
    set_row(19, 0, 1, 1,   1, 1,  6, 0, 4, 3);
    set_row(20, 0, 1, 1,   1, 0,  7, 0, 3, 3);
    set_row(21, 0, 1, 1,   1, 0, 12, 1, 2, 3);
    set_row(22, 0, 1, 1,   1, 1, 13, 0, 1, 3);
    set_row(23, 0, 1, 1,   0, 0,  0, 0, 0, 3);
    set_row(24, 0, 1, 1,   0, 0,  0, 0, 0, 3);

    rst_n = 1'b0;
    en = 0; clear = 0; soi = 0; rd0.rd_ready = 0;
    en1 = 0; clear1 = 0; soi1 = 0; rd1.rd_ready = 0;
    repeat (3) step();
    chk0("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      en = tbl[i].en;
      soi = tbl[i].soi;
      rd0.rd_ready = tbl[i].rdy;
      step();
      chk0($sformatf("row%0d", i), tbl[i].v, tbl[i].val, tbl[i].ts,
           tbl[i].lost, tbl[i].cnt, tbl[i].drp);
    end

    rd0.rd_ready = 0;
    en = 1;
    soi = 1; step();
    soi = 0; step();
    soi = 1; step();
    soi = 0; step();
    chk0("fill4", 1, 1, 14, 0, 4, 3);
    soi = 1; clear = 1; step();
    chk0("clear", 0, 0, 0, 0, 0, 0);
    clear = 0; step();
    chk0("post_clear", 0, 0, 0, 0, 0, 0);
    soi = 0; step();
    chk0("ts_restart", 1, 0, 1, 0, 1, 0);

    #2 rst_n = 1'b0;
    #1;
    chk("async_rst valid", 32'(rd0.rd_valid), 32'd0);
    chk("async_rst count", 32'(count0), 32'd0);
    en = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int c = 0; c < 18; c++) begin
      en1 = 1;
      soi1 = (c == 15 || c == 16);
      step();
    end
    chk("wrap count", 32'(count1), 32'd3);
    chk("wrap ts0", 32'(rd1.rd_ts), 32'd0);
    en1 = 0; rd1.rd_ready = 1; step();
    chk("wrap ts15", 32'(rd1.rd_ts), 32'd15);
    chk("wrap val15", 32'(rd1.rd_value), 32'd1);
    step();
    chk("wrap ts1", 32'(rd1.rd_ts), 32'd1);
    chk("wrap val1", 32'(rd1.rd_value), 32'd0);
    rd1.rd_ready = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
